// File: rtl/pop_store_if.sv
// ---------------------------------------------------------------------------
// pop_store_if
// Bundles the write, read and status signals of the population store.
//   wr_valid/wr_child1/wr_child2/wr_fit1/wr_fit2 : child pair offered for storage
//   wr_ready                                     : store accepts a pair this cycle
//   rd_req                                       : request the next chromosome pair
//   rd_valid/rd_chrom1/rd_chrom2                 : registered read data
//   best_chrom/best_fit                          : best chromosome seen since reset
//   gen_count/finished                           : generation progress
// master = client side (GA pipeline / bench), slave = pop_store.
// ---------------------------------------------------------------------------
interface pop_store_if;
    logic                wr_valid;
    logic        [31:0]  wr_child1;
    logic        [31:0]  wr_child2;
    logic signed [26:0]  wr_fit1;
    logic signed [26:0]  wr_fit2;
    logic                wr_ready;
    logic                rd_req;
    logic                rd_valid;
    logic        [31:0]  rd_chrom1;
    logic        [31:0]  rd_chrom2;
    logic        [31:0]  best_chrom;
    logic signed [26:0]  best_fit;
    logic        [15:0]  gen_count;
    logic                finished;

    modport master (
        output wr_valid, wr_child1, wr_child2, wr_fit1, wr_fit2, rd_req,
        input  wr_ready, rd_valid, rd_chrom1, rd_chrom2,
               best_chrom, best_fit, gen_count, finished
    );

    modport slave (
        input  wr_valid, wr_child1, wr_child2, wr_fit1, wr_fit2, rd_req,
        output wr_ready, rd_valid, rd_chrom1, rd_chrom2,
               best_chrom, best_fit, gen_count, finished
    );
endinterface

// File: rtl/pop_store.sv
// ---------------------------------------------------------------------------
// pop_store
// Population storage for a genetic-algorithm pipeline. Child pairs are written
// two entries at a time into a circular buffer of POP_SIZE chromosomes; the
// fitness stage reads pairs back in the same circular order. The block tracks
// the best chromosome ever written and counts completed generations, stopping
// after MAX_GEN of them.
// Ports:
//   clk   : single clock, posedge
//   reset : synchronous, active-high
//   bus   : pop_store_if.slave (write pair, read pair, best/generation status)
// ---------------------------------------------------------------------------
module pop_store #(
    parameter int POP_SIZE = 16,
    parameter int MAX_GEN  = 100
) (
    input  logic       clk,
    input  logic       reset,
    pop_store_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int FIT_W  = 27;
    localparam int PTR_W  = $clog2(POP_SIZE);

    localparam logic signed [FIT_W-1:0] FIT_MIN   = {1'b1, {(FIT_W-1){1'b0}}};
    localparam logic        [PTR_W-1:0] LAST_PAIR = PTR_W'(POP_SIZE - 2);
    localparam logic        [15:0]      GEN_LIMIT = 16'(MAX_GEN);

    typedef enum logic [1:0] {FILL, RUN, DONE} state_t;

    state_t                   state;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic                     wr_ready_q;
    logic                     finished_q;
    logic [15:0]              gen_q;
    logic                     rd_vld_p1;
    logic [DATA_W-1:0]        rd1_p1;
    logic [DATA_W-1:0]        rd2_p1;
    logic [DATA_W-1:0]        best_chrom_q;
    logic signed [FIT_W-1:0]  best_fit_q;

    // Storage is data only: never reset, only read once the first fill is done.
    logic [DATA_W-1:0]        mem [POP_SIZE];

    logic                     wr_acc;
    logic                     wr_wrap;
    logic                     rd_acc;
    logic [PTR_W-1:0]         wr_ptr_odd;
    logic [PTR_W-1:0]         rd_ptr_odd;
    logic [15:0]              gen_next;
    logic [DATA_W-1:0]        cand_chrom;
    logic signed [FIT_W-1:0]  cand_fit;

    // Child2 wins only on strictly larger fitness; ties go to child1.
    function automatic logic pick_child2(input logic signed [FIT_W-1:0] f1,
                                         input logic signed [FIT_W-1:0] f2);
        return f2 > f1;
    endfunction

    // Strict signed improvement over the current best.
    function automatic logic improves(input logic signed [FIT_W-1:0] cand,
                                      input logic signed [FIT_W-1:0] best);
        return cand > best;
    endfunction

    always_comb begin
        wr_acc     = bus.wr_valid && wr_ready_q;
        wr_wrap    = (wr_ptr == LAST_PAIR);
        rd_acc     = bus.rd_req && (state == RUN);
        // Pointers always sit on even entries, so the partner entry is ptr|1.
        wr_ptr_odd = {wr_ptr[PTR_W-1:1], 1'b1};
        rd_ptr_odd = {rd_ptr[PTR_W-1:1], 1'b1};
        gen_next   = gen_q + 16'd1;
        cand_chrom = bus.wr_child1;
        cand_fit   = bus.wr_fit1;
        if (pick_child2(bus.wr_fit1, bus.wr_fit2)) begin
            cand_chrom = bus.wr_child2;
            cand_fit   = bus.wr_fit2;
        end
    end

    // Write port; reset suppresses a same-cycle write.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr]     <= bus.wr_child1;
            mem[wr_ptr_odd] <= bus.wr_child2;
        end
    end

    // Control, read pipeline (_p1) and best tracking. The read samples mem at
    // the same edge as a write, so a colliding read sees the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FILL;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wr_ready_q   <= 1'b1;
            finished_q   <= 1'b0;
            gen_q        <= '0;
            rd_vld_p1    <= 1'b0;
            rd1_p1       <= '0;
            rd2_p1       <= '0;
            best_chrom_q <= '0;
            best_fit_q   <= FIT_MIN;
        end else begin
            rd_vld_p1 <= rd_acc;
            if (rd_acc) begin
                rd1_p1 <= mem[rd_ptr];
                rd2_p1 <= mem[rd_ptr_odd];
                rd_ptr <= rd_ptr + PTR_W'(2);
            end

            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(2);
                if (improves(cand_fit, best_fit_q)) begin
                    best_chrom_q <= cand_chrom;
                    best_fit_q   <= cand_fit;
                end
            end

            case (state)
                FILL: begin
                    if (wr_acc && wr_wrap) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (wr_acc && wr_wrap) begin
                        gen_q <= gen_next;
                        if (gen_next == GEN_LIMIT) begin
                            state      <= DONE;
                            wr_ready_q <= 1'b0;
                            finished_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    assign bus.wr_ready   = wr_ready_q;
    assign bus.rd_valid   = rd_vld_p1;
    assign bus.rd_chrom1  = rd1_p1;
    assign bus.rd_chrom2  = rd2_p1;
    assign bus.best_chrom = best_chrom_q;
    assign bus.best_fit   = best_fit_q;
    assign bus.gen_count  = gen_q;
    assign bus.finished   = finished_q;

endmodule
